// File: rtl/sipo_deserializer_if.sv
// rtl/sipo_deserializer_if.sv - control, serial input and parallel output bundle of the deserializer
interface sipo_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             clear;
    logic             en;
    logic             din;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             busy;

    modport master (
        output start, clear, en, din,
        input  dout, valid, busy
    );

    modport slave (
        input  start, clear, en, din,
        output dout, valid, busy
    );
endinterface

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-in/parallel-out word assembler with bit counter and IDLE/SHIFT FSM
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    sipo_deserializer_if.slave   bus
);
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_next;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] w_dout_next;
    logic             r_valid;
    logic             w_valid_next;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {r_shreg[WIDTH-2:0], bus.din};
        end else begin : g_lsb_first
            assign w_shifted = {bus.din, r_shreg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            r_shreg <= w_shreg_next;
            r_dout  <= w_dout_next;
            r_valid <= w_valid_next;
        end
    end

    // clear outranks everything, including the completing edge; dout is never touched by an abort
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_shreg_next = r_shreg;
        w_dout_next  = r_dout;
        w_valid_next = 1'b0;
        if (bus.clear) begin
            w_next_state = S_IDLE;
            w_cnt_next   = '0;
            w_shreg_next = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_next_state = S_SHIFT;
                        w_cnt_next   = '0;
                        w_shreg_next = '0;
                    end
                end
                S_SHIFT: begin
                    if (bus.en) begin
                        w_shreg_next = w_shifted;
                        if (r_cnt == LAST) begin
                            w_dout_next  = w_shifted;
                            w_valid_next = 1'b1;
                            w_next_state = S_IDLE;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    assign bus.dout  = r_dout;
    assign bus.valid = r_valid;
    assign bus.busy  = (r_state == S_SHIFT);
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - MSB-first and LSB-first instances driven in parallel against a bit-queue model
module tb_sipo_deserializer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sipo_deserializer_if #(.WIDTH(8)) if_m ();
    sipo_deserializer_if #(.WIDTH(8)) if_l ();

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (if_m)
    );

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (if_l)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit       m_busy  = 1'b0;
    bit       m_valid = 1'b0;
    bit [7:0] m_dout_m = 8'h00;
    bit [7:0] m_dout_l = 8'h00;
    bit       m_bits[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy   = 1'b0;
        m_valid  = 1'b0;
        m_dout_m = 8'h00;
        m_dout_l = 8'h00;
        m_bits.delete();
    endtask

    // A word is simply the first eight sampled bits of a frame, placed by arrival order
    task automatic model_edge(input bit s, input bit c, input bit e, input logic d);
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_valid = 1'b0;
        if (c) begin
            m_busy = 1'b0;
            m_bits.delete();
        end else if (!m_busy) begin
            if (s) begin
                m_busy = 1'b1;
                m_bits.delete();
            end
        end else if (e) begin
            m_bits.push_back(d === 1'b1);
            if (m_bits.size() == 8) begin
                for (int i = 0; i < 8; i++) begin
                    m_dout_m[7 - i] = m_bits[i];
                    m_dout_l[i]     = m_bits[i];
                end
                m_valid = 1'b1;
                m_busy  = 1'b0;
                m_bits.delete();
            end
        end
    endtask

    task automatic check_all();
        chk("dout_msb",  if_m.dout,  m_dout_m);
        chk("dout_lsb",  if_l.dout,  m_dout_l);
        chk("valid_msb", if_m.valid, m_valid);
        chk("valid_lsb", if_l.valid, m_valid);
        chk("busy_msb",  if_m.busy,  m_busy);
        chk("busy_lsb",  if_l.busy,  m_busy);
    endtask

    task automatic step(input bit s, input bit c, input bit e, input logic d);
        if_m.start = s; if_l.start = s;
        if_m.clear = c; if_l.clear = c;
        if_m.en    = e; if_l.en    = e;
        if_m.din   = d; if_l.din   = d;
        @(posedge clk);
        cyc++;
        model_edge(s, c, e, d);
        @(negedge clk);
        check_all();
    endtask

    task automatic send_frame(input logic [7:0] w);
        step(1'b1, 1'b0, 1'b0, 1'bx);
        for (int i = 7; i >= 0; i--) step(1'b0, 1'b0, 1'b1, w[i]);
    endtask

    int cs, vc1, vc2;

    initial begin
        if_m.start = 1'b0; if_l.start = 1'b0;
        if_m.clear = 1'b0; if_l.clear = 1'b0;
        if_m.en    = 1'b0; if_l.en    = 1'b0;
        if_m.din   = 1'b0; if_l.din   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_dout",  if_m.dout,  32'h00);
        chk("reset_valid", if_m.valid, 32'h0);
        chk("reset_busy",  if_m.busy,  32'h0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Cases 1 and 2: 1,0,1,1,0,0,1,0 on both instances
        step(1'b1, 1'b0, 1'b0, 1'bx);
        cs = cyc;
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] w;
            w = 8'hB2;
            step(1'b0, 1'b0, 1'b1, w[i]);
            if (i > 0) chk("busy_during_frame", if_m.busy, 32'h1);
        end
        chk("c1_dout_msb", if_m.dout, 32'hB2);
        chk("c2_dout_lsb", if_l.dout, 32'h4D);
        chk("c1_valid", if_m.valid, 32'h1);
        chk("c1_busy_falls", if_m.busy, 32'h0);
        chk("c1_latency", cyc - cs, 32'd8);
        step(1'b0, 1'b0, 1'b0, 1'bx);
        chk("c1_valid_one_cycle", if_m.valid, 32'h0);

        // Case 3: en gaps of 3 after bits 2 and 5
        step(1'b1, 1'b0, 1'b0, 1'bx);
        cs = cyc;
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] w;
            w = 8'hB2;
            step(1'b0, 1'b0, 1'b1, w[i]);
            if (i == 6 || i == 3) begin
                repeat (3) begin
                    step(1'b0, 1'b0, 1'b0, 1'bx);
                    chk("c3_busy_in_gap", if_m.busy, 32'h1);
                    chk("c3_no_valid_in_gap", if_m.valid, 32'h0);
                end
            end
        end
        chk("c3_dout", if_m.dout, 32'hB2);
        chk("c3_valid", if_m.valid, 32'h1);
        chk("c3_latency", cyc - cs, 32'd14);

        // Case 4: asynchronous reset after 4 bits, then 8'hFF
        step(1'b1, 1'b0, 1'b0, 1'bx);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("c4_async_dout", if_m.dout, 32'h00);
        chk("c4_async_busy", if_m.busy, 32'h0);
        chk("c4_async_valid", if_m.valid, 32'h0);
        model_reset();
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            chk("c4_idle_after_reset", if_m.busy, 32'h0);
        end
        send_frame(8'hFF);
        chk("c4_dout", if_m.dout, 32'hFF);
        chk("c4_valid", if_m.valid, 32'h1);

        // Case 5: clear on the 8th-bit edge, then 8'h3C
        send_frame(8'hB2);
        step(1'b1, 1'b0, 1'b0, 1'bx);
        for (int i = 7; i >= 1; i--) begin
            logic [7:0] w;
            w = 8'h3C;
            step(1'b0, 1'b0, 1'b1, w[i]);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("c5_abort_no_valid", if_m.valid, 32'h0);
        chk("c5_abort_keeps_dout", if_m.dout, 32'hB2);
        chk("c5_abort_idle", if_m.busy, 32'h0);
        send_frame(8'h3C);
        chk("c5_dout", if_m.dout, 32'h3C);

        // Case 6: back-to-back A5 / 5A, start in the valid cycle, stray starts mid-frame
        send_frame(8'hA5);
        chk("c6_first_dout", if_m.dout, 32'hA5);
        chk("c6_first_valid", if_m.valid, 32'h1);
        vc1 = cyc;
        step(1'b1, 1'b0, 1'b0, 1'bx);
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] w;
            w = 8'h5A;
            step((i == 5 || i == 2), 1'b0, 1'b1, w[i]);
        end
        vc2 = cyc;
        chk("c6_second_dout", if_m.dout, 32'h5A);
        chk("c6_second_valid", if_m.valid, 32'h1);
        chk("c6_spacing", vc2 - vc1, 32'd9);

        // Randomized traffic, X on din whenever en is low
        for (int i = 0; i < 600; i++) begin
            bit s, c, e;
            logic d;
            s = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 23) == 0);
            e = ($urandom_range(0, 3) != 0);
            d = e ? logic'($urandom_range(0, 1)) : 1'bx;
            step(s, c, e, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-in/parallel-out deserializer that sits directly downstream of the FF_D stage. It consumes the registered serial bit stream on the flip-flop's Q output and assembles it into WIDTH-bit words. Each completed word is reported with a one-cycle valid strobe. The block is built as a shift register of D flip-flops plus a bit counter and a two-state control FSM.

Parameters:
- WIDTH, 8, bits per word; legal range WIDTH >= 2.
- MSB_FIRST, 1, bit order. 1 means the first received bit lands in dout[WIDTH-1]; 0 means it lands in dout[0].

Ports:
- clk, input, 1, single system clock; all state updates on its rising edge.
- reset, input, 1, asynchronous active-low reset.
- start, input, 1, begin a new word. Sampled only in IDLE.
- clear, input, 1, synchronous abort of the frame in progress.
- en, input, 1, bit-sample enable. din is shifted in only on cycles where en=1.
- din, input, 1, serial data bit, driven by the upstream FF_D Q output.
- dout, output, WIDTH, last completed word.
- valid, output, 1, one-cycle strobe marking that dout was just updated.
- busy, output, 1, high while a frame is being received (state SHIFT).

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - state = IDLE, shift register = 0, bit counter = 0.
  - dout = 0, valid = 0, busy = 0.
  - Outputs hold these values while reset stays low.
- Bit counter width is $clog2(WIDTH). It counts 0..WIDTH-1 and never wraps past WIDTH-1.
- FSM states:
  - IDLE: busy=0. start=1 at an edge → SHIFT; counter=0; shift register=0. din is not sampled on the start cycle.
  - SHIFT: busy=1. At each edge with en=1:
    - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], din}.
    - MSB_FIRST=0: shreg <= {din, shreg[WIDTH-1:1]}.
    - counter increments.
  - SHIFT with en=0: shift register and counter hold; there is no timeout.
  - Completion: edge with en=1 and counter == WIDTH-1. dout <= assembled word including this final din; valid <= 1; state → IDLE; counter → 0.
- valid is high for exactly one cycle, the cycle after the final sampling edge; it is 0 otherwise.
- Latency: the word appears on dout one edge after its WIDTH-th sampled bit.
- dout holds its value until the next completion. An abort never modifies it.
- start while in SHIFT is ignored.
- Back-to-back frames: start=1 in the same cycle valid=1 is legal (state is IDLE) and begins the next frame. No bubble is required beyond the start cycle itself.
- clear=1 has priority over start, en and completion:
  - state → IDLE, counter → 0, shreg → 0, valid → 0, dout unchanged.
  - clear on the would-be completion edge aborts the frame: no valid, dout unchanged.
- Reset asserted mid-frame discards the partial word immediately. After release the block waits in IDLE for start.
- X on din while en=0 must not propagate into shreg.

Test Plan:
1. WIDTH=8, MSB_FIRST=1: reset pulse, start, then din = 1,0,1,1,0,0,1,0 with en=1 on 8 consecutive edges → dout=8'hB2, valid high exactly one cycle after the 8th edge, busy falls with it.
2. MSB_FIRST=0, same bit sequence → dout=8'h4D, single valid pulse.
3. Same stream as case 1 with en=0 gaps of 3 cycles after bits 2 and 5 → dout=8'hB2, valid delayed by 6 cycles, busy stays high through the gaps.
4. Drop reset low after 4 bits, release, start, send 8'hFF (all ones) → outputs 0 during reset, no valid for the aborted frame, then dout=8'hFF.
5. Assert clear on the 8th-bit edge → no valid, dout keeps previous 8'hB2. Then start plus 8 bits of 8'h3C → dout=8'h3C.
6. Two back-to-back frames (8'hA5 then 8'h5A, start asserted in the valid cycle) → two valid pulses 9 cycles apart, dout=8'hA5 then 8'h5A. Extra start pulses mid-frame are ignored.
